// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
// mixer_pkg : shared types and numeric helpers for the gain mixer
// Rev 1.0
// ============================================================================
package mixer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Headroom of $clog2(CHANNELS) bits keeps the full-precision sum from wrapping
  function automatic int acc_width(input int bitsize, input int channels);
    return 2 * bitsize + $clog2(channels);
  endfunction

  function automatic longint sat_max(input int bitsize);
    return (longint'(1) << (bitsize - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int bitsize);
    return -(longint'(1) << (bitsize - 1));
  endfunction

  function automatic longint gain_unity(input int bitsize);
    return longint'(1) << (bitsize - 2);
  endfunction

  localparam int     DEF_BITSIZE = 16;
  localparam longint SAT_MAX     = sat_max(DEF_BITSIZE);
  localparam longint SAT_MIN     = sat_min(DEF_BITSIZE);
  localparam longint GAIN_UNITY  = gain_unity(DEF_BITSIZE);

endpackage
`default_nettype wire

// File: rtl/mixer_scheduler_if.sv
`default_nettype none
// ============================================================================
// mixer_scheduler_if : frame strobe, operand buses and mixed-sample outputs
// Rev 1.0
// ============================================================================
interface mixer_scheduler_if #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4
);
  logic                         start;
  logic [CHANNELS*BITSIZE-1:0]  in_bus;
  logic [CHANNELS*BITSIZE-1:0]  gain_bus;
  logic [CHANNELS-1:0]          ch_enable;
  logic signed [BITSIZE-1:0]    out;
  logic                         out_valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output start, in_bus, gain_bus, ch_enable,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  start, in_bus, gain_bus, ch_enable,
    output out, out_valid, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// mac_unit : registered multiplier, full-precision accumulator, shift/saturate
// Rev 1.0
// ============================================================================
module mac_unit
  import mixer_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      acc_clear,
  input  wire logic                      mul_en,
  input  wire logic                      acc_en,
  input  wire logic                      out_en,
  input  wire logic                      op_en,
  input  wire logic signed [BITSIZE-1:0] op_a,
  input  wire logic signed [BITSIZE-1:0] op_b,
  output logic signed [BITSIZE-1:0]      out,
  output logic                           out_valid
);
  localparam int PW   = 2 * BITSIZE;
  localparam int ACCW = acc_width(BITSIZE, CHANNELS);
  localparam logic signed [ACCW-1:0] LIM_HI = ACCW'(sat_max(BITSIZE));
  localparam logic signed [ACCW-1:0] LIM_LO = ACCW'(sat_min(BITSIZE));

  logic signed [PW-1:0]      prod_q, prod_d;
  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic signed [BITSIZE-1:0] out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACCW-1:0]    shifted;
  logic signed [ACCW-1:0]    sat;

  always_comb begin
    prod_d = prod_q;
    if (mul_en) begin
      prod_d = op_en ? PW'(op_a) * PW'(op_b) : '0;
    end

    acc_d = acc_q;
    if (acc_clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + ACCW'(prod_q);
    end

    // Arithmetic shift floors toward -inf; no rounding term is added
    shifted = acc_q >>> (BITSIZE - 2);
    if (shifted > LIM_HI) begin
      sat = LIM_HI;
    end else if (shifted < LIM_LO) begin
      sat = LIM_LO;
    end else begin
      sat = shifted;
    end

    out_d       = out_en ? sat[BITSIZE-1:0] : out_q;
    out_valid_d = out_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: rtl/mixer_scheduler.sv
`default_nettype none
// ============================================================================
// mixer_scheduler : per-frame scheduler feeding one shared MAC across channels
// Rev 1.0
// ============================================================================
module mixer_scheduler
  import mixer_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mixer_scheduler_if.slave bus
);
  localparam int IDXW = $clog2(CHANNELS);
  localparam int BW   = CHANNELS * BITSIZE;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHANNELS - 1);

  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [BW-1:0]        in_s_q, in_s_d;
  logic [BW-1:0]        gain_s_q, gain_s_d;
  logic [CHANNELS-1:0]  en_s_q, en_s_d;
  logic                 overrun_q, overrun_d;

  logic                      acc_clear, mul_en, acc_en, out_en, op_en;
  logic signed [BITSIZE-1:0] op_a, op_b;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_s_d    = in_s_q;
    gain_s_d  = gain_s_q;
    en_s_d    = en_s_q;
    acc_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          in_s_d    = bus.in_bus;
          gain_s_d  = bus.gain_bus;
          en_s_d    = bus.ch_enable;
          idx_d     = '0;
          acc_clear = 1'b1;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    overrun_d = bus.start && (state_q != S_IDLE);

    // The product register lags one slot, so the first MAC edge has nothing to add yet
    mul_en = (state_q == S_MAC);
    acc_en = ((state_q == S_MAC) && (idx_q != '0)) || (state_q == S_DRAIN);
    out_en = (state_q == S_OUT);

    op_a  = in_s_q[int'(idx_q)*BITSIZE +: BITSIZE];
    op_b  = gain_s_q[int'(idx_q)*BITSIZE +: BITSIZE];
    op_en = en_s_q[idx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      in_s_q    <= '0;
      gain_s_q  <= '0;
      en_s_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_s_q    <= in_s_d;
      gain_s_q  <= gain_s_d;
      en_s_q    <= en_s_d;
      overrun_q <= overrun_d;
    end
  end

  mac_unit #(
    .BITSIZE  (BITSIZE),
    .CHANNELS (CHANNELS)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .acc_clear (acc_clear),
    .mul_en    (mul_en),
    .acc_en    (acc_en),
    .out_en    (out_en),
    .op_en     (op_en),
    .op_a      (op_a),
    .op_b      (op_b),
    .out       (bus.out),
    .out_valid (bus.out_valid)
  );

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.overrun = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_mixer_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mixer_scheduler : scoreboard bench with directed and random frames
// Rev 1.0
// ============================================================================
module tb_mixer_scheduler;
  localparam int B   = 16;
  localparam int C   = 4;
  localparam int LAT = C + 2;
  localparam int GAP = C + 3;
  localparam int U   = 16'h4000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mixer_scheduler_if #(.BITSIZE(B), .CHANNELS(C)) bus ();

  mixer_scheduler #(.BITSIZE(B), .CHANNELS(C)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     at;
  } exp_t;

  exp_t exp_q[$];
  int   ov_q[$];
  int   ecount    = 0;
  int   next_free = 0;
  int   last_acc  = -100;
  int   total     = 0;
  int   bad       = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic logic [C*B-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Reference: exact integer sum, floor division by 2^14, clamp to 16-bit range
  function automatic longint model_mix(input logic [C*B-1:0] ins, input logic [C*B-1:0] gains,
                                       input logic [C-1:0] en);
    longint s = 0;
    longint q;
    for (int k = 0; k < C; k++) begin
      if (en[k]) s += longint'($signed(ins[k*B +: B])) * longint'($signed(gains[k*B +: B]));
    end
    q = s / 16384;
    if (s < 0 && (s % 16384) != 0) q -= 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Called at a negedge; start is sampled at the next posedge
  task automatic pulse_start(input logic [C*B-1:0] ins, input logic [C*B-1:0] gains,
                             input logic [C-1:0] en);
    int e;
    bus.in_bus    = ins;
    bus.gain_bus  = gains;
    bus.ch_enable = en;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    e = ecount;
    if (e >= next_free) begin
      exp_q.push_back('{val: model_mix(ins, gains, en), at: e + LAT});
      next_free = e + GAP;
      last_acc  = e;
    end else begin
      ov_q.push_back(e);
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.in_bus    = {$urandom(), $urandom()};
    bus.gain_bus  = {$urandom(), $urandom()};
    bus.ch_enable = 4'($urandom());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    bit   ev, eo, eb;
    exp_t x;
    if (!rst) begin
      ev = (exp_q.size() > 0) && (exp_q[0].at == ecount);
      chk("out_valid", longint'(bus.out_valid), longint'(ev));
      if (ev) begin
        x = exp_q.pop_front();
        if (bus.out_valid) chk("out", longint'(bus.out), x.val);
      end
      eo = (ov_q.size() > 0) && (ov_q[0] == ecount);
      chk("overrun", longint'(bus.overrun), longint'(eo));
      if (eo) void'(ov_q.pop_front());
      eb = (ecount >= last_acc) && (ecount <= last_acc + LAT - 1);
      chk("busy", longint'(bus.busy), longint'(eb));
    end
  end

  initial begin
    logic [C*B-1:0] ins, gns;
    int w;
    bus.start     = 1'b0;
    bus.in_bus    = '0;
    bus.gain_bus  = '0;
    bus.ch_enable = '0;
    #1 rst = 1'b1;
    idle(3);
    chk("rst_out", longint'(bus.out), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_overrun", longint'(bus.overrun), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Unity mix, saturation, truncation, enables
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111); idle(8);
    pulse_start(pack4(30000, 30000, 30000, 30000), pack4(U, U, U, U), 4'b1111); idle(8);
    pulse_start(pack4(-30000, -30000, -30000, -30000), pack4(U, U, U, U), 4'b1111); idle(8);
    pulse_start(pack4(-3, 77, 77, 77), pack4(16'h2000, U, U, U), 4'b0001); idle(8);
    pulse_start(pack4(3, 77, 77, 77), pack4(16'h2000, U, U, U), 4'b0001); idle(8);
    pulse_start(pack4(100, 200, 300, 400), pack4(U, U, U, U), 4'b0101); idle(8);
    pulse_start(pack4(100, 200, 300, 400), pack4(U, U, U, U), 4'b0000); idle(8);

    // Overrun three clocks in, start in the OUT cycle, start in the out_valid cycle
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111); idle(2);
    pulse_start(pack4(9, 9, 9, 9), pack4(U, U, U, U), 4'b1111); idle(8);
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111); idle(5);
    pulse_start(pack4(5, 5, 5, 5), pack4(U, U, U, U), 4'b1111); idle(8);
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111); idle(6);
    pulse_start(pack4(100, 200, 300, 400), pack4(U, U, U, U), 4'b1111); idle(8);

    // Start held high for three sampled edges
    pulse_start(pack4(11, 22, 33, 44), pack4(U, U, U, U), 4'b1111);
    pulse_start(pack4(1, 1, 1, 1), pack4(U, U, U, U), 4'b1111);
    pulse_start(pack4(1, 1, 1, 1), pack4(U, U, U, U), 4'b1111); idle(8);

    // Reset two clocks into a frame
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out", longint'(bus.out), 0);
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    exp_q.delete();
    ov_q.delete();
    next_free = 0;
    last_acc  = -100;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(10);
    pulse_start(pack4(1000, 2000, -500, 0), pack4(U, U, U, U), 4'b1111); idle(8);

    // Random frames with random spacing (some land as overruns)
    for (int i = 0; i < 80; i++) begin
      ins = {$urandom(), $urandom()};
      gns = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) gns = pack4(U, U, U, U);
      pulse_start(ins, gns, 4'($urandom()));
      idle($urandom_range(0, 9));
    end

    w = 0;
    while ((exp_q.size() > 0 || ov_q.size() > 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_frames", longint'(exp_q.size()), 0);
    chk("drain_overruns", longint'(ov_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
